muldiv_unit: RTL

//  Iterative RV32M multiply/divide execute unit; sits beside the ALU in EX.

---
 rtl/muldiv_if.sv | 25 ++
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_if.sv
// Request/response bundle between the EX stage and the iterative multiply/divide unit.
// The master issues operations and consumes results; the slave is the unit itself.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       Funct3;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Result;

    modport master (
        output in_valid, Funct3, SrcA, SrcB, flush, out_ready,
        input  in_ready, out_valid, Result
    );

    modport slave (
        input  in_valid, Funct3, SrcA, SrcB, flush, out_ready,
        output in_ready, out_valid, Result
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// one bit per cycle on unsigned magnitudes with the sign fix applied on entry to DONE.
module muldiv_unit #(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t state_reg, state_next;

    logic [2:0]       op_reg;
    logic             neg_reg;
    logic             sign_a_reg;
    logic             special_reg;
    logic [WIDTH-1:0] special_val_reg;
    logic [WIDTH-1:0] hi_reg;
    logic [WIDTH-1:0] lo_reg;
    logic [WIDTH-1:0] b_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] result_reg;

    // ---------------- request decode (only meaningful on the accept edge) ----------------
    logic [2:0]       f3;
    logic             a_signed, b_signed, sign_a, sign_b;
    logic             is_div, div_zero, div_ovf, early, accept;
    logic [WIDTH-1:0] mag_a, mag_b, special_val;

    assign f3 = bus.Funct3;

    always_comb begin
        a_signed = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
        b_signed = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
        sign_a   = a_signed & bus.SrcA[WIDTH-1];
        sign_b   = b_signed & bus.SrcB[WIDTH-1];
        mag_a    = sign_a ? -bus.SrcA : bus.SrcA;
        mag_b    = sign_b ? -bus.SrcB : bus.SrcB;
        is_div   = f3[2];
        div_zero = is_div && (bus.SrcB == '0);
        div_ovf  = is_div && !f3[0] && (bus.SrcA == MOST_NEG) && (bus.SrcB == '1);
        // f3[1] separates REM/REMU from DIV/DIVU
        if (div_zero) begin
            special_val = f3[1] ? bus.SrcA : '1;
        end else begin
            special_val = f3[1] ? '0 : bus.SrcA;
        end
        early  = EARLY_OUT && (div_zero || div_ovf);
        accept = (state_reg == S_IDLE) && bus.in_valid && !bus.flush;
    end

    // ---------------- one iteration step ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
    logic [WIDTH:0]   div_shifted;
    logic [WIDTH-1:0] div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_next, div_lo_next;
    logic [WIDTH-1:0] hi_next, lo_next;
    logic             last;

    always_comb begin
        mul_sum     = {1'b0, hi_reg} + (lo_reg[0] ? {1'b0, b_reg} : '0);
        mul_hi_next = mul_sum[WIDTH:1];
        mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

        // partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits
        div_shifted = {hi_reg, lo_reg[WIDTH-1]};
        div_ge      = div_shifted >= {1'b0, b_reg};
        div_diff    = div_shifted[WIDTH-1:0] - b_reg;
        div_hi_next = div_ge ? div_diff : div_shifted[WIDTH-1:0];
        div_lo_next = {lo_reg[WIDTH-2:0], div_ge};

        hi_next = (state_reg == S_DIV) ? div_hi_next : mul_hi_next;
        lo_next = (state_reg == S_DIV) ? div_lo_next : mul_lo_next;
        last    = (count_reg == CW'(WIDTH - 1));
    end

    // ---------------- final result with sign fix ----------------
    logic [2*WIDTH-1:0] prod, prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix, final_val;

    always_comb begin
        prod     = {mul_hi_next, mul_lo_next};
        prod_fix = neg_reg ? -prod : prod;
        quo_fix  = neg_reg ? -div_lo_next : div_lo_next;
        rem_fix  = sign_a_reg ? -div_hi_next : div_hi_next;
        case (op_reg)
            3'b000:                 final_val = prod_fix[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_fix[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_val = quo_fix;
            default:                final_val = rem_fix;
        endcase
        // with EARLY_OUT=0 the iteration runs anyway but the architectural answer wins
        if (special_reg) begin
            final_val = special_val_reg;
        end
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_next = state_reg;
        if (bus.flush) begin
            state_next = S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (accept) begin
                        if (early) begin
                            state_next = S_DONE;
                        end else begin
                            state_next = is_div ? S_DIV : S_MUL;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (last) begin
                        state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        state_next = S_IDLE;
                    end
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        bus.in_ready  = (state_reg == S_IDLE);
        bus.out_valid = (state_reg == S_DONE) && !bus.flush;
        bus.Result    = result_reg;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_reg          <= '0;
            neg_reg         <= 1'b0;
            sign_a_reg      <= 1'b0;
            special_reg     <= 1'b0;
            special_val_reg <= '0;
            hi_reg          <= '0;
            lo_reg          <= '0;
            b_reg           <= '0;
            count_reg       <= '0;
            result_reg      <= '0;
        end else if (bus.flush) begin
            count_reg <= '0;
        end else if (accept) begin
            op_reg          <= f3;
            neg_reg         <= sign_a ^ sign_b;
            sign_a_reg      <= sign_a;
            special_reg     <= div_zero || div_ovf;
            special_val_reg <= special_val;
            hi_reg          <= '0;
            lo_reg          <= is_div ? mag_a : mag_b;
            b_reg           <= is_div ? mag_b : mag_a;
            count_reg       <= '0;
            if (early) begin
                result_reg <= special_val;
            end
        end else if ((state_reg == S_MUL) || (state_reg == S_DIV)) begin
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            count_reg <= last ? '0 : count_reg + CW'(1);
            if (last) begin
                result_reg <= final_val;
            end
        end
    end
endmodule
